// File: rtl/dma_utils_pkg.sv
// Shared scheduler types: FSM state encoding and the WAIT watchdog limit.
// The default descriptor-slot count macro DMA_NUM_DESC is provided here when not set externally.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

package dma_utils_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ABORT  = 3'd4,
        ST_FINISH = 3'd5
    } sched_state_e;

    localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/dma_desc_sched_if.sv
// Grant/completion handshake between the descriptor scheduler and the transfer executor.

interface dma_desc_sched_if #(
    parameter int IDX_W = 1
);
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_ready;
    logic             desc_done;
    logic             desc_err;

    modport sched (
        output grant_valid,
        output grant_idx,
        input  grant_ready,
        input  desc_done,
        input  desc_err
    );

    modport exec (
        input  grant_valid,
        input  grant_idx,
        output grant_ready,
        output desc_done,
        output desc_err
    );
endinterface

// File: rtl/dma_prio_enc.sv
// Lowest-set-bit finder: one-hot of the winning bit, its binary index and an any-set flag.

module dma_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);
    // w_seen[k] is high when any bit below position k is set
    logic [N:0] w_seen;

    assign w_seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign o_onehot[gi]  = i_vec[gi] & ~w_seen[gi];
            assign w_seen[gi+1]  = w_seen[gi] | i_vec[gi];
        end
    endgenerate

    assign o_valid = w_seen[N];

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (o_onehot[i]) o_idx = W'(i);
        end
    end
endmodule

// File: rtl/dma_desc_sched.sv
// DMA descriptor scheduler: walks the enabled slots lowest-first, one grant at a time.
// Define DMA_SCHED_WDOG_EN to bound the WAIT state with a 16-bit watchdog.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

module dma_desc_sched
    import dma_utils_pkg::*;
#(
    parameter int NUM_DESC = `DMA_NUM_DESC,
    parameter int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go_i,
    input  logic                abort_i,
    input  logic [NUM_DESC-1:0] desc_en_i,
    output logic                grant_valid_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    input  logic                grant_ready_i,
    input  logic                desc_done_i,
    input  logic                desc_err_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o
);
    sched_state_e        r_state;
    logic                r_go;
    logic [NUM_DESC-1:0] r_pend;
    logic [NUM_DESC-1:0] r_onehot;
    logic [IDX_W-1:0]    r_idx;
    logic                r_grant_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [NUM_DESC-1:0] w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_valid;

`ifdef DMA_SCHED_WDOG_EN
    logic [15:0]         r_wdog;
`endif

    dma_prio_enc #(
        .N (NUM_DESC),
        .W (IDX_W)
    ) u_prio_enc (
        .i_vec    (r_pend),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            // Treat go as already high so a level held through reset is not a launch edge
            r_go          <= 1'b1;
            r_pend        <= '0;
            r_onehot      <= '0;
            r_idx         <= '0;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
`ifdef DMA_SCHED_WDOG_EN
            r_wdog        <= '0;
`endif
        end else begin
            r_go <= go_i;
            case (r_state)
                ST_IDLE: begin
                    if (go_i && !r_go) begin
                        r_pend  <= desc_en_i;
                        r_busy  <= 1'b1;
                        r_state <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (abort_i || !w_pick_valid) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= 1'b0;
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx         <= w_pick_idx;
                        r_onehot      <= w_pick_onehot;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Abort wins over a same-cycle ready: the offer is withdrawn unaccepted
                    if (abort_i) begin
                        r_grant_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_error       <= 1'b0;
                        r_state       <= ST_FINISH;
                    end else if (grant_ready_i) begin
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_WAIT;
`ifdef DMA_SCHED_WDOG_EN
                        r_wdog        <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    // A completion arriving with abort already finished the descriptor
                    if (desc_done_i) begin
                        r_pend <= r_pend & ~r_onehot;
                        if (desc_err_i || abort_i) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_error <= desc_err_i;
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_PICK;
                        end
                    end else if (abort_i) begin
                        r_state <= ST_ABORT;
                    end
`ifdef DMA_SCHED_WDOG_EN
                    else if (r_wdog == WDOG_LIMIT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
`endif
                end
                ST_ABORT: begin
                    if (desc_done_i) begin
                        r_pend  <= r_pend & ~r_onehot;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= desc_err_i;
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (!go_i) begin
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                    r_error       <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_valid_o = r_grant_valid;
    assign grant_idx_o   = r_idx;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign error_o       = r_error;
endmodule

// File: tb/tb_dma_desc_sched.sv
// Randomized bench for dma_desc_sched: a bench-side executor answers grants and the
// expected grant order / error outcome comes from a list model of the enable mask.
`timescale 1ns/1ps

module tb_dma_desc_sched;
    localparam int N  = 4;
    localparam int IW = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] desc_en = '0;
    logic         busy;
    logic         done;
    logic         error;

    dma_desc_sched_if #(.IDX_W(IW)) bus ();

    always #5 clk = ~clk;

    dma_desc_sched #(
        .NUM_DESC (N),
        .IDX_W    (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .go_i          (go),
        .abort_i       (abort),
        .desc_en_i     (desc_en),
        .grant_valid_o (bus.grant_valid),
        .grant_idx_o   (bus.grant_idx),
        .grant_ready_i (bus.grant_ready),
        .desc_done_i   (bus.desc_done),
        .desc_err_i    (bus.desc_err),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error)
    );

    int            total = 0;
    int            bad = 0;
    logic [IW-1:0] got_q[$];
    logic [IW-1:0] exp_q[$];
    logic          exp_err;
    int            unstable;
    bit            timed_out;
    logic          obs_done, obs_err, idle_done, idle_err;

    // Reference: enabled slots are served in ascending order; the first failing one ends the run
    task automatic model_run(input logic [N-1:0] en, input logic [N-1:0] errm);
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                exp_q.push_back(IW'(i));
                if (errm[i]) begin
                    exp_err = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Executor: accept each offer after a random delay, complete it after another random delay
    task automatic run_exec(input logic [N-1:0] en, input logic [N-1:0] en_after,
                            input logic [N-1:0] errm, input int rmax, input int dmax);
        int            phase, cnt;
        logic [IW-1:0] cur, prev;
        bit            have_prev, finished;
        got_q.delete();
        unstable  = 0;
        phase     = 0;
        cnt       = int'($urandom_range(rmax, 0));
        have_prev = 0;
        finished  = 0;
        cur       = '0;
        prev      = '0;
        desc_en   = en;
        go        = 1'b0;
        @(negedge clk);
        go = 1'b1;
        for (int cyc = 0; cyc < 500 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) desc_en = en_after;
            bus.grant_ready = 1'b0;
            bus.desc_done   = 1'b0;
            bus.desc_err    = 1'b0;
            if (done) begin
                finished = 1;
            end else if (phase == 0 && bus.grant_valid) begin
                if (have_prev && bus.grant_idx !== prev) unstable++;
                prev      = bus.grant_idx;
                have_prev = 1;
                if (cnt == 0) begin
                    bus.grant_ready = 1'b1;
                    got_q.push_back(bus.grant_idx);
                    cur       = bus.grant_idx;
                    phase     = 1;
                    have_prev = 0;
                    cnt       = int'($urandom_range(dmax, 0));
                end else begin
                    cnt--;
                end
            end else if (phase == 1) begin
                if (bus.grant_valid) unstable++;
                if (cnt == 0) begin
                    bus.desc_done = 1'b1;
                    bus.desc_err  = errm[cur];
                    phase         = 0;
                    cnt           = int'($urandom_range(rmax, 0));
                end else begin
                    cnt--;
                end
            end
        end
        timed_out = !finished;
        obs_done  = done;
        obs_err   = error;
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        idle_done = done;
        idle_err  = error;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.grant_valid); end
        total++; if (bus.grant_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.grant_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: valid=%b busy=%b done=%b error=%b", bus.grant_valid, busy, done, error);
    endtask

    task automatic test_directed();
        logic [N-1:0] t_en[5], t_after[5], t_err[5];
        t_en[0] = 4'b0011; t_after[0] = 4'b0011; t_err[0] = 4'b0000;
        t_en[1] = 4'b0010; t_after[1] = 4'b0010; t_err[1] = 4'b0000;
        t_en[2] = 4'b0011; t_after[2] = 4'b0011; t_err[2] = 4'b0001;
        t_en[3] = 4'b0101; t_after[3] = 4'b1010; t_err[3] = 4'b0000;
        t_en[4] = 4'b1000; t_after[4] = 4'b1111; t_err[4] = 4'b1000;
        for (int t = 0; t < 5; t++) begin
            model_run(t_en[t], t_err[t]);
            run_exec(t_en[t], t_after[t], t_err[t], 2, 2);
            total++; if (timed_out) begin bad++; $display("FAIL dir%0d_timeout: no done_o within budget", t); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL dir%0d_grant_count: got %0d want %0d", t, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL dir%0d_grant%0d_idx: got %0d want %0d", t, k, got_q[k], exp_q[k]); end
            end
            total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL dir%0d_done: got %b want 1", t, obs_done); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL dir%0d_error: got %b want %b", t, obs_err, exp_err); end
            total++; if (unstable != 0) begin bad++; $display("FAIL dir%0d_grant_stable: got %0d glitches want 0", t, unstable); end
            total++; if ({idle_done, idle_err} !== 2'b00) begin bad++; $display("FAIL dir%0d_clear: got done/err %b want 00", t, {idle_done, idle_err}); end
            $display("directed %0d: en=%b err=%b grants=%0d done=%b error=%b", t, t_en[t], t_err[t], got_q.size(), obs_done, obs_err);
        end
    endtask

    task automatic test_empty();
        bit saw_grant;
        saw_grant = 0;
        desc_en   = '0;
        go        = 1'b0;
        @(negedge clk);
        go = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.grant_valid) saw_grant = 1;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done: got %b want 1", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL empty_error: got %b want 0", error); end
        total++; if (saw_grant) begin bad++; $display("FAIL empty_grant: got a grant want none"); end
        go = 1'b0;
        repeat (2) @(negedge clk);
        $display("empty: done=%b grant_seen=%0d", done, saw_grant);
    endtask

    task automatic test_abort_issue();
        desc_en = 4'b0011;
        go      = 1'b0;
        @(negedge clk);
        go = 1'b1;
        for (int k = 0; k < 20 && !bus.grant_valid; k++) @(negedge clk);
        total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL abort_issue_offer: got valid %b want 1", bus.grant_valid); end
        abort           = 1'b1;
        bus.grant_ready = 1'b1;
        @(negedge clk);
        abort           = 1'b0;
        bus.grant_ready = 1'b0;
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL abort_issue_withdraw: got valid %b want 0", bus.grant_valid); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_issue_done: got %b want 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_issue_busy: got %b want 0", busy); end
        go = 1'b0;
        repeat (2) @(negedge clk);
        $display("abort in ISSUE: valid=%b done=%b", bus.grant_valid, done);
    endtask

    task automatic test_abort_wait();
        bit held, regrant;
        held    = 1;
        regrant = 0;
        desc_en = 4'b0011;
        go      = 1'b0;
        @(negedge clk);
        go = 1'b1;
        for (int k = 0; k < 20 && !bus.grant_valid; k++) @(negedge clk);
        total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL abort_wait_offer: got valid %b want 1", bus.grant_valid); end
        bus.grant_ready = 1'b1;
        @(negedge clk);
        bus.grant_ready = 1'b0;
        abort           = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) held = 0;
            if (bus.grant_valid) regrant = 1;
            @(negedge clk);
        end
        total++; if (!held) begin bad++; $display("FAIL abort_wait_hold: got busy=%b done=%b want busy=1 done=0", busy, done); end
        bus.desc_done = 1'b1;
        @(negedge clk);
        bus.desc_done = 1'b0;
        if (bus.grant_valid) regrant = 1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_wait_done: got %b want 1", done); end
        total++; if (regrant) begin bad++; $display("FAIL abort_wait_regrant: got a second grant want none"); end
        go = 1'b0;
        repeat (2) @(negedge clk);
        $display("abort in WAIT: done=%b error=%b", done, error);
    endtask

    task automatic test_reset_midrun();
        bit quiet;
        quiet   = 1;
        desc_en = 4'b0110;
        go      = 1'b0;
        @(negedge clk);
        go = 1'b1;
        for (int k = 0; k < 20 && !bus.grant_valid; k++) @(negedge clk);
        bus.grant_ready = 1'b1;
        @(negedge clk);
        bus.grant_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy || bus.grant_valid) quiet = 0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL reset_midrun_quiet: got done=%b busy=%b want both 0", done, busy); end
        go = 1'b0;
        @(negedge clk);
        $display("reset mid-run: done=%b busy=%b", done, busy);
    endtask

    task automatic test_go_through_reset();
        bit quiet;
        quiet   = 1;
        desc_en = 4'b0101;
        go      = 1'b1;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || done || bus.grant_valid) quiet = 0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL go_reset_no_run: run started from held go"); end
        model_run(4'b0101, 4'b0000);
        run_exec(4'b0101, 4'b0101, 4'b0000, 1, 1);
        total++; if (got_q.size() != exp_q.size() || timed_out) begin bad++; $display("FAIL go_reset_relaunch: got %0d grants want %0d", got_q.size(), exp_q.size()); end
        total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL go_reset_done: got %b want 1", obs_done); end
        $display("go through reset: grants after relaunch=%0d", got_q.size());
    endtask

    task automatic test_random();
        logic [N-1:0] en, after, errm;
        for (int t = 0; t < 40; t++) begin
            en    = N'($urandom);
            after = N'($urandom);
            errm  = N'($urandom & $urandom & $urandom);
            model_run(en, errm);
            run_exec(en, after, errm, 3, 3);
            total++; if (timed_out) begin bad++; $display("FAIL rnd%0d_timeout: no done_o within budget", t); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_grant_count: got %0d want %0d", t, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd%0d_grant%0d_idx: got %0d want %0d", t, k, got_q[k], exp_q[k]); end
            end
            total++; if (obs_err !== exp_err || obs_done !== 1'b1) begin bad++; $display("FAIL rnd%0d_status: got done=%b err=%b want done=1 err=%b", t, obs_done, obs_err, exp_err); end
            total++; if (unstable != 0) begin bad++; $display("FAIL rnd%0d_grant_stable: got %0d glitches want 0", t, unstable); end
            $display("random %0d: en=%b err=%b grants=%0d error=%b", t, en, errm, got_q.size(), obs_err);
        end
    endtask

    initial begin
        bus.grant_ready = 1'b0;
        bus.desc_done   = 1'b0;
        bus.desc_err    = 1'b0;
        test_reset();
        test_directed();
        test_empty();
        test_abort_issue();
        test_abort_wait();
        test_reset_midrun();
        test_go_through_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
